// File: rtl/result_bcd_converter.sv
// Sequential signed-binary to BCD converter using double-dabble, one bit per clock.
// Optional leading-digit blanking (4'hF) is enabled by defining RESULT_BCD_BLANK_EN.
module result_bcd_converter #(
    parameter int NB = 48,
    parameter int ND = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NB-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_neg,
    output logic [4*ND-1:0] out_bcd,
    output logic            busy
);

    localparam int CW = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q;
    logic [NB-1:0]   mag_q;
    logic [4*ND-1:0] bcd_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    logic            out_valid_q;
    logic            out_neg_q;
    logic [4*ND-1:0] out_bcd_q;

    logic [NB-1:0]   in_mag_d;
    logic [4*ND-1:0] bcd_adj_d;
    logic [4*ND-1:0] bcd_step_d;
    logic [NB-1:0]   mag_step_d;
    logic [4*ND-1:0] result_d;

    // Two's-complement negate in NB bits maps -2^(NB-1) onto 2^(NB-1) unsigned.
    assign in_mag_d = in_data[NB-1] ? ((~in_data) + NB'(1)) : in_data;

    always_comb begin
        bcd_adj_d = bcd_q;
        for (int unsigned i = 0; i < ND; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_step_d = {bcd_adj_d[4*ND-2:0], mag_q[NB-1]};
    assign mag_step_d = {mag_q[NB-2:0], 1'b0};

`ifdef RESULT_BCD_BLANK_EN
    // Scan from the top digit down; blank until the first nonzero digit, digit 0 always shown.
    always_comb begin : blank_leading
        logic        seen;
        int unsigned idx;
        result_d = bcd_step_d;
        seen     = 1'b0;
        for (int unsigned k = 0; k < ND - 1; k++) begin
            idx = ND - 1 - k;
            if (bcd_step_d[4*idx +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            if (!seen) begin
                result_d[4*idx +: 4] = 4'hF;
            end
        end
    end
`else
    assign result_d = bcd_step_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_neg_q   <= 1'b0;
            out_bcd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        neg_q   <= in_data[NB-1];
                        mag_q   <= in_mag_d;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_step_d;
                    mag_q <= mag_step_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NB - 1)) begin
                        out_bcd_q   <= result_d;
                        out_neg_q   <= neg_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = ~in_ready;
    assign out_valid = out_valid_q;
    assign out_neg   = out_neg_q;
    assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: decimal reference model, decoupled monitor.
module tb_result_bcd_converter;

    localparam int NB = 48;
    localparam int ND = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [NB-1:0]   in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_neg;
    logic [4*ND-1:0] out_bcd;
    logic            busy;

    result_bcd_converter #(.NB(NB), .ND(ND)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_neg(out_neg), .out_bcd(out_bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            neg;
        logic [4*ND-1:0] bcd;
        int              acc;
    } exp_t;

    exp_t q[$];
    int   cmps = 0;
    int   errs = 0;
    int   cyc  = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits of |x| by repeated division, then optional blanking.
    function automatic exp_t model(input logic [NB-1:0] x);
        exp_t        e;
        longint      v;
        longint      m;
        int          top;
        logic signed [NB-1:0] xs;
        xs    = x;
        v     = longint'(xs);
        e.neg = (v < 0);
        m     = (v < 0) ? -v : v;
        e.bcd = '0;
        top   = 0;
        for (int d = 0; d < ND; d++) begin
            e.bcd[4*d +: 4] = 4'(m % 10);
            if ((m % 10) != 0) top = d;
            m = m / 10;
        end
`ifdef RESULT_BCD_BLANK_EN
        for (int d = top + 1; d < ND; d++) e.bcd[4*d +: 4] = 4'hF;
`endif
        e.acc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    if (!prev_v) chk("latency", 64'(cyc - q[0].acc), 64'(NB));
                    chk("out_bcd", 64'(out_bcd), 64'(q[0].bcd));
                    chk("out_neg", 64'(out_neg), 64'(q[0].neg));
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_v = out_valid;
        end
    end

    task automatic send(input logic [NB-1:0] d);
        exp_t e;
        bit   ok;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = model(d);
        e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic drain(input int stall);
        bit ok;
        ok = 0;
        for (int i = 0; i < NB + 8; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("out_valid_timeout", 64'd0, 64'd1);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = NB'(64'h0000_1234_5678_9ABC);
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_busy", 64'(busy), 64'd1);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);
        chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic run(input logic [NB-1:0] d, input int stall);
        send(d);
        drain(stall);
    endtask

    initial begin
        logic [NB-1:0] r;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_bcd", 64'(out_bcd), 64'd0);
        chk("rst_out_neg", 64'(out_neg), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run(NB'(15), 0);
        run(NB'(-7), 1);
        run(NB'(0), 0);
        r = '0; r[NB-1] = 1'b1;
        run(r, 2);
        r = '1; r[NB-1] = 1'b0;
        run(r, 0);
        run(NB'(15), 5);

        // Abort mid-conversion; the aborted input must never appear.
        send(NB'(123456));
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_out_bcd", 64'(out_bcd), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        run(NB'(9), 0);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: r = NB'($urandom_range(0, 999));
                1: r = -NB'($urandom_range(1, 99999));
                default: r = NB'({$urandom, $urandom});
            endcase
            run(r, int'($urandom_range(0, 3)));
        end

        repeat (5) @(posedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
